// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register with architectural HI/LO and LLbit
module mem_wb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_LLbit_we,
    input  logic        mem_LLbit_value,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_LLbit_we,
    output logic        wb_LLbit_value,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        LLbit_o
);

    // mem stalled while wb runs: wb must drain, so a bubble is inserted
    logic bubble_stall;
    assign bubble_stall = stall[4] && !stall[5];

    // Pipeline register: flush/bubble clear, free-running capture, full stall holds
    always_ff @(posedge clk) begin
        if (!reset_n || flush || bubble_stall) begin
            wb_we          <= 1'b0;
            wb_waddr       <= 5'd0;
            wb_wdata       <= 32'd0;
            wb_whilo       <= 1'b0;
            wb_hi          <= 32'd0;
            wb_lo          <= 32'd0;
            wb_LLbit_we    <= 1'b0;
            wb_LLbit_value <= 1'b0;
        end else if (!stall[4]) begin
            wb_we          <= mem_we;
            wb_waddr       <= mem_waddr;
            wb_wdata       <= mem_wdata;
            wb_whilo       <= mem_whilo;
            wb_hi          <= mem_hi;
            wb_lo          <= mem_lo;
            wb_LLbit_we    <= mem_LLbit_we;
            wb_LLbit_value <= mem_LLbit_value;
        end
    end

    // Architectural HI/LO commit from the wb slot; a flushed instruction never commits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
        end else if (wb_whilo && !flush) begin
            hi_o <= wb_hi;
            lo_o <= wb_lo;
        end
    end

    // LLbit: exceptions break any LL/SC reservation, winning over a pending write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            LLbit_o <= 1'b0;
        end else if (flush) begin
            LLbit_o <= 1'b0;
        end else if (wb_LLbit_we) begin
            LLbit_o <= wb_LLbit_value;
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// tb/tb_mem_wb.sv - scoreboard testbench for mem_wb
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  stall;
    logic        flush;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_LLbit_we;
    logic        mem_LLbit_value;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;

    mem_wb dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .flush           (flush),
        .mem_we          (mem_we),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .mem_whilo       (mem_whilo),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_LLbit_we    (mem_LLbit_we),
        .mem_LLbit_value (mem_LLbit_value),
        .wb_we           (wb_we),
        .wb_waddr        (wb_waddr),
        .wb_wdata        (wb_wdata),
        .wb_whilo        (wb_whilo),
        .wb_hi           (wb_hi),
        .wb_lo           (wb_lo),
        .wb_LLbit_we     (wb_LLbit_we),
        .wb_LLbit_value  (wb_LLbit_value),
        .hi_o            (hi_o),
        .lo_o            (lo_o),
        .LLbit_o         (LLbit_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
        logic [31:0] hi_o;
        logic [31:0] lo_o;
        logic        llbit;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    obs_t  exp;
    int    tests = 0;
    int    fails = 0;

    // next-cycle stimulus, applied at the falling edge
    logic        n_reset_n, n_flush, n_we, n_whilo, n_llwe, n_llval;
    logic [5:0]  n_stall;
    logic [4:0]  n_waddr;
    logic [31:0] n_wdata, n_hi, n_lo;

    task automatic idle_in();
        n_reset_n = 1'b1; n_flush = 1'b0; n_stall = 6'd0;
        n_we = 1'b0; n_waddr = 5'd0; n_wdata = 32'd0;
        n_whilo = 1'b0; n_hi = 32'd0; n_lo = 32'd0;
        n_llwe = 1'b0; n_llval = 1'b0;
    endtask

    task automatic exp_wb_zero();
        exp.we = 0; exp.waddr = 0; exp.wdata = 0; exp.whilo = 0;
        exp.hi = 0; exp.lo = 0; exp.llwe = 0; exp.llval = 0;
    endtask

    task automatic step(input string name);
        @(negedge clk);
        reset_n = n_reset_n; flush = n_flush; stall = n_stall;
        mem_we = n_we; mem_waddr = n_waddr; mem_wdata = n_wdata;
        mem_whilo = n_whilo; mem_hi = n_hi; mem_lo = n_lo;
        mem_LLbit_we = n_llwe; mem_LLbit_value = n_llval;
        @(posedge clk);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // monitor: compare DUT state against the oldest expectation after each edge
    initial begin
        obs_t  e;
        obs_t  act;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{wb_we, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo,
                        wb_LLbit_we, wb_LLbit_value, hi_o, lo_o, LLbit_o};
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL %s: got we=%b wa=%0d wd=%h whilo=%b hi=%h lo=%h llwe=%b llv=%b hi_o=%h lo_o=%h ll=%b ; want we=%b wa=%0d wd=%h whilo=%b hi=%h lo=%h llwe=%b llv=%b hi_o=%h lo_o=%h ll=%b",
                             nm, act.we, act.waddr, act.wdata, act.whilo, act.hi, act.lo,
                             act.llwe, act.llval, act.hi_o, act.lo_o, act.llbit,
                             e.we, e.waddr, e.wdata, e.whilo, e.hi, e.lo,
                             e.llwe, e.llval, e.hi_o, e.lo_o, e.llbit);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0; flush = 0; stall = 0; mem_we = 0; mem_waddr = 0; mem_wdata = 0;
        mem_whilo = 0; mem_hi = 0; mem_lo = 0; mem_LLbit_we = 0; mem_LLbit_value = 0;
        exp = '0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            n_reset_n = 0; n_stall = 0; n_flush = 1'($urandom);
            n_we = 1'b1; n_waddr = 5'($urandom); n_wdata = $urandom;
            n_whilo = 1'b1; n_hi = $urandom; n_lo = $urandom;
            n_llwe = 1'b1; n_llval = 1'b1;
            step("reset");
        end

        // release and capture
        idle_in(); n_we = 1; n_waddr = 5; n_wdata = 32'h12345678;
        exp.we = 1; exp.waddr = 5; exp.wdata = 32'h12345678;
        step("capture");

        idle_in(); n_stall = 6'b011111; n_we = 1; n_waddr = 6; n_wdata = 32'h11111111;
        exp_wb_zero();
        step("stall_bubble");

        idle_in(); n_we = 1; n_waddr = 7; n_wdata = 32'hDEADBEEF;
        exp.we = 1; exp.waddr = 7; exp.wdata = 32'hDEADBEEF;
        step("load_deadbeef");

        for (int i = 0; i < 3; i++) begin
            idle_in(); n_stall = 6'b111111; n_we = 1; n_waddr = 8; n_wdata = 32'h55555555;
            step("stall_hold");
        end

        idle_in(); n_we = 1; n_waddr = 9; n_wdata = 32'hCAFEF00D;
        exp.waddr = 9; exp.wdata = 32'hCAFEF00D;
        step("stall_release");

        // HI/LO two-edge commit
        idle_in(); n_whilo = 1; n_hi = 32'hAAAA0000; n_lo = 32'h0000BBBB;
        exp_wb_zero(); exp.whilo = 1; exp.hi = 32'hAAAA0000; exp.lo = 32'h0000BBBB;
        step("hilo_edge1");

        idle_in();
        exp_wb_zero(); exp.hi_o = 32'hAAAA0000; exp.lo_o = 32'h0000BBBB;
        step("hilo_edge2");

        idle_in();
        step("hilo_persist");

        // back-to-back HI/LO writes
        idle_in(); n_whilo = 1; n_hi = 32'h1; n_lo = 32'h2;
        exp.whilo = 1; exp.hi = 32'h1; exp.lo = 32'h2;
        step("hilo_b2b_1");

        idle_in(); n_whilo = 1; n_hi = 32'h3; n_lo = 32'h4;
        exp.hi = 32'h3; exp.lo = 32'h4; exp.hi_o = 32'h1; exp.lo_o = 32'h2;
        step("hilo_b2b_2");

        idle_in();
        exp_wb_zero(); exp.hi_o = 32'h3; exp.lo_o = 32'h4;
        step("hilo_b2b_3");

        // LL then SC
        idle_in(); n_llwe = 1; n_llval = 1;
        exp.llwe = 1; exp.llval = 1;
        step("ll_edge1");

        idle_in();
        exp_wb_zero(); exp.llbit = 1;
        step("ll_edge2");

        idle_in(); n_we = 1; n_waddr = 3; n_wdata = 32'h1; n_llwe = 1; n_llval = 0;
        exp.we = 1; exp.waddr = 3; exp.wdata = 32'h1; exp.llwe = 1; exp.llval = 0;
        step("sc_edge1");

        idle_in();
        exp_wb_zero(); exp.llbit = 0;
        step("sc_edge2");

        // flush clears LLbit despite a pending write
        idle_in(); n_llwe = 1; n_llval = 1;
        exp.llwe = 1; exp.llval = 1;
        step("ll2_edge1");

        idle_in(); n_llwe = 1; n_llval = 1;
        exp.llbit = 1;
        step("ll2_edge2");

        idle_in(); n_flush = 1; n_llwe = 1; n_llval = 1; n_we = 1; n_waddr = 4; n_wdata = 32'h44;
        exp_wb_zero(); exp.llbit = 0;
        step("flush_llbit");

        idle_in();
        step("after_flush_ll");

        // flush blocks HI/LO commit
        idle_in(); n_whilo = 1; n_hi = 32'h77777777; n_lo = 32'h88888888;
        exp.whilo = 1; exp.hi = 32'h77777777; exp.lo = 32'h88888888;
        step("hilo_pre_flush");

        idle_in(); n_flush = 1;
        exp_wb_zero();
        step("flush_hilo");

        idle_in();
        step("after_flush_hilo");

        // flush wins over a full stall
        idle_in(); n_we = 1; n_waddr = 1; n_wdata = 32'hA5;
        exp.we = 1; exp.waddr = 1; exp.wdata = 32'hA5;
        step("pre_flush_stall");

        idle_in(); n_flush = 1; n_stall = 6'b111111;
        exp_wb_zero();
        step("flush_over_stall");

        // reset mid-operation
        idle_in(); n_whilo = 1; n_hi = 32'h9; n_lo = 32'hA; n_llwe = 1; n_llval = 1;
        exp.whilo = 1; exp.hi = 32'h9; exp.lo = 32'hA; exp.llwe = 1; exp.llval = 1;
        step("pre_reset");

        idle_in(); n_reset_n = 0; n_whilo = 1; n_hi = 32'hF; n_lo = 32'hF;
        exp = '0;
        step("reset_mid");

        idle_in();
        step("after_reset");

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
